// File: rtl/regex_pc_scheduler.sv
// Thread scheduler around the regex CPU: two ping-pong PC FIFOs (current / next character),
// character-advance sequencing and end-of-run detection.
module regex_pc_scheduler #(
  parameter int PC_WIDTH        = 8,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                in_pc_valid,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                in_pc_is_directed_to_current,
  output logic                in_pc_ready,
  output logic                out_pc_valid,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                out_pc_ready,
  input  logic                cpu_idle,
  input  logic                at_end_of_string,
  output logic                advance_character,
  output logic                done,
  output logic                overflow
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PTR_W = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADVANCE, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [1:0][PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [1:0][PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic                  cur_sel_reg, cur_sel_next;
  logic                  quiet_q_reg;
  logic                  overflow_reg, overflow_next;

  logic [1:0]                      fifo_full;
  logic [1:0]                      fifo_empty;
  logic [1:0]                      wr_en;
  logic [1:0][FIFO_DEPTH_LOG2-1:0] wr_addr;
  logic [1:0][PC_WIDTH-1:0]        fifo_head;
  logic [PC_WIDTH-1:0]             wr_data;
  logic                            tgt_sel;
  logic                            nxt_sel;
  logic                            start_fire;
  logic                            push;
  logic                            pop;
  logic                            quiet;
  logic                            decide;

  // Physical FIFO storage; head is read combinationally so a pushed PC shows one cycle later.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [PC_WIDTH-1:0] mem [DEPTH];

      assign fifo_full[gi]  = (wr_ptr_reg[gi][PTR_W-1] != rd_ptr_reg[gi][PTR_W-1]) &&
                              (wr_ptr_reg[gi][PTR_W-2:0] == rd_ptr_reg[gi][PTR_W-2:0]);
      assign fifo_empty[gi] = (wr_ptr_reg[gi] == rd_ptr_reg[gi]);
      assign fifo_head[gi]  = mem[rd_ptr_reg[gi][PTR_W-2:0]];
      assign wr_en[gi]      = (start_fire && (cur_sel_reg == 1'(gi))) ||
                              (push && (tgt_sel == 1'(gi)));
      assign wr_addr[gi]    = start_fire ? '0 : wr_ptr_reg[gi][PTR_W-2:0];

      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[wr_addr[gi]] <= wr_data;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    cur_sel_next      = cur_sel_reg;
    overflow_next     = overflow_reg;
    in_pc_ready       = 1'b0;
    out_pc_valid      = 1'b0;
    out_pc            = '0;
    advance_character = 1'b0;
    done              = 1'b0;
    nxt_sel           = ~cur_sel_reg;
    tgt_sel           = in_pc_is_directed_to_current ? cur_sel_reg : nxt_sel;
    start_fire        = 1'b0;
    push              = 1'b0;
    pop               = 1'b0;
    quiet             = 1'b0;
    decide            = 1'b0;
    wr_data           = in_pc;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_fire                = 1'b1;
          wr_data                   = start_pc;
          wr_ptr_next               = '0;
          rd_ptr_next               = '0;
          wr_ptr_next[cur_sel_reg]  = PTR_W'(1);
          overflow_next             = 1'b0;
          state_next                = S_RUN;
        end
      end

      S_RUN: begin
        // Ready uses the pre-pop full flag even when pushing into the FIFO being popped.
        in_pc_ready  = ~fifo_full[tgt_sel];
        out_pc_valid = ~fifo_empty[cur_sel_reg];
        out_pc       = out_pc_valid ? fifo_head[cur_sel_reg] : '0;
        push         = in_pc_valid && in_pc_ready;
        pop          = out_pc_valid && out_pc_ready;
        if (push) begin
          wr_ptr_next[tgt_sel] = wr_ptr_reg[tgt_sel] + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_next[cur_sel_reg] = rd_ptr_reg[cur_sel_reg] + PTR_W'(1);
        end
        if (in_pc_valid && fifo_full[tgt_sel]) begin
          overflow_next = 1'b1;
        end
        // Two consecutive quiet cycles before trusting that the CPU has nothing in flight.
        quiet  = fifo_empty[cur_sel_reg] && cpu_idle && !in_pc_valid && !pop;
        decide = quiet && quiet_q_reg;
        if (decide) begin
          state_next = (fifo_empty[nxt_sel] || at_end_of_string) ? S_DONE : S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        advance_character = 1'b1;
        cur_sel_next      = ~cur_sel_reg;
        state_next        = S_RUN;
      end

      S_DONE: begin
        done        = 1'b1;
        wr_ptr_next = '0;
        rd_ptr_next = '0;
        state_next  = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cur_sel_reg  <= 1'b0;
      quiet_q_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      cur_sel_reg  <= cur_sel_next;
      quiet_q_reg  <= quiet;
      overflow_reg <= overflow_next;
    end
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_regex_pc_scheduler.sv
// Self-checking bench for regex_pc_scheduler: directed scenarios plus a randomized run
// compared against a queue-based model of the scheduling rules.
module tb_regex_pc_scheduler;
  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] start_pc;
  logic       in_pc_valid;
  logic [7:0] in_pc;
  logic       in_pc_is_directed_to_current;
  logic       in_pc_ready;
  logic       out_pc_valid;
  logic [7:0] out_pc;
  logic       out_pc_ready;
  logic       cpu_idle;
  logic       at_end_of_string;
  logic       advance_character;
  logic       done;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  regex_pc_scheduler #(.PC_WIDTH(8), .FIFO_DEPTH_LOG2(4)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .start                        (start),
    .start_pc                     (start_pc),
    .in_pc_valid                  (in_pc_valid),
    .in_pc                        (in_pc),
    .in_pc_is_directed_to_current (in_pc_is_directed_to_current),
    .in_pc_ready                  (in_pc_ready),
    .out_pc_valid                 (out_pc_valid),
    .out_pc                       (out_pc),
    .out_pc_ready                 (out_pc_ready),
    .cpu_idle                     (cpu_idle),
    .at_end_of_string             (at_end_of_string),
    .advance_character            (advance_character),
    .done                         (done),
    .overflow                     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    start_pc = 8'h00;
    in_pc_valid = 1'b0;
    in_pc = 8'h00;
    in_pc_is_directed_to_current = 1'b0;
    out_pc_ready = 1'b0;
    cpu_idle = 1'b0;
    at_end_of_string = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] pc);
    start = 1'b1;
    start_pc = pc;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (in_pc_ready !== 1'b0) begin errors++; $display("FAIL reset_in_pc_ready got %b exp 0", in_pc_ready); end
    checks++; if (out_pc_valid !== 1'b0) begin errors++; $display("FAIL reset_out_pc_valid got %b exp 0", out_pc_valid); end
    checks++; if (out_pc !== 8'h00) begin errors++; $display("FAIL reset_out_pc got %h exp 00", out_pc); end
    checks++; if (advance_character !== 1'b0) begin errors++; $display("FAIL reset_advance got %b exp 0", advance_character); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    tick();
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_single_thread();
    int first_adv;
    int adv_cnt;
    int done_cnt;
    do_reset();
    do_start(8'h05);
    out_pc_ready = 1'b1;
    cpu_idle = 1'b1;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h05) begin errors++; $display("FAIL single_first_pc got v=%b pc=%h exp v=1 pc=05", out_pc_valid, out_pc); end
    tick();
    out_pc_ready = 1'b0;
    cpu_idle = 1'b0;
    in_pc_valid = 1'b1;
    in_pc = 8'h06;
    in_pc_is_directed_to_current = 1'b0;
    @(negedge clk);
    checks++; if (in_pc_ready !== 1'b1) begin errors++; $display("FAIL single_push_ready got %b exp 1", in_pc_ready); end
    tick();
    in_pc_valid = 1'b0;
    cpu_idle = 1'b1;
    first_adv = -1;
    adv_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (advance_character === 1'b1) begin
        adv_cnt++;
        if (first_adv < 0) first_adv = i;
      end
      if (done === 1'b1) done_cnt++;
      if (i == 3) begin
        checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h06) begin errors++; $display("FAIL single_next_pc got v=%b pc=%h exp v=1 pc=06", out_pc_valid, out_pc); end
      end
      tick();
    end
    checks++; if (first_adv != 2) begin errors++; $display("FAIL single_adv_latency got %0d exp 2", first_adv); end
    checks++; if (adv_cnt != 1) begin errors++; $display("FAIL single_adv_count got %0d exp 1", adv_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL single_no_done got %0d exp 0", done_cnt); end
    $display("test_single_thread: start 05 -> advance -> 06");
  endtask

  task automatic test_split();
    int adv_cnt;
    adv_cnt = 0;
    do_reset();
    do_start(8'h01);
    out_pc_ready = 1'b1;
    @(negedge clk);
    if (advance_character === 1'b1) adv_cnt++;
    tick();
    out_pc_ready = 1'b0;
    in_pc_valid = 1'b1;
    in_pc = 8'h0A;
    in_pc_is_directed_to_current = 1'b1;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b0) begin errors++; $display("FAIL split_empty_between got %b exp 0", out_pc_valid); end
    if (advance_character === 1'b1) adv_cnt++;
    tick();
    in_pc = 8'h0B;
    out_pc_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h0A) begin errors++; $display("FAIL split_first got v=%b pc=%h exp v=1 pc=0a", out_pc_valid, out_pc); end
    if (advance_character === 1'b1) adv_cnt++;
    tick();
    in_pc_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h0B) begin errors++; $display("FAIL split_second got v=%b pc=%h exp v=1 pc=0b", out_pc_valid, out_pc); end
    if (advance_character === 1'b1) adv_cnt++;
    tick();
    checks++; if (adv_cnt != 0) begin errors++; $display("FAIL split_no_advance got %0d exp 0", adv_cnt); end
    $display("test_split: 0a then 0b on current character");
  endtask

  task automatic test_empty_next();
    int done_at;
    int done_cnt;
    int adv_cnt;
    do_reset();
    do_start(8'h00);
    out_pc_ready = 1'b1;
    cpu_idle = 1'b1;
    tick();
    out_pc_ready = 1'b0;
    done_at = -1;
    done_cnt = 0;
    adv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (advance_character === 1'b1) adv_cnt++;
      tick();
    end
    checks++; if (done_at != 2) begin errors++; $display("FAIL empty_done_time got %0d exp 2", done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL empty_done_count got %0d exp 1", done_cnt); end
    checks++; if (adv_cnt != 0) begin errors++; $display("FAIL empty_no_advance got %0d exp 0", adv_cnt); end
    do_start(8'h33);
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h33) begin errors++; $display("FAIL empty_restart got v=%b pc=%h exp v=1 pc=33", out_pc_valid, out_pc); end
    tick();
    $display("test_empty_next: done without advance, restart accepted");
  endtask

  task automatic test_end_of_string();
    int done_at;
    int adv_cnt;
    do_reset();
    do_start(8'h02);
    out_pc_ready = 1'b1;
    tick();
    out_pc_ready = 1'b0;
    in_pc_valid = 1'b1;
    in_pc = 8'h03;
    in_pc_is_directed_to_current = 1'b0;
    tick();
    in_pc_valid = 1'b0;
    cpu_idle = 1'b1;
    at_end_of_string = 1'b1;
    done_at = -1;
    adv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1 && done_at < 0) done_at = i;
      if (advance_character === 1'b1) adv_cnt++;
      tick();
    end
    checks++; if (done_at != 2) begin errors++; $display("FAIL eos_done_time got %0d exp 2", done_at); end
    checks++; if (adv_cnt != 0) begin errors++; $display("FAIL eos_no_advance got %0d exp 0", adv_cnt); end
    $display("test_end_of_string: done at terminator with next non-empty");
  endtask

  task automatic test_full();
    bit seen;
    do_reset();
    do_start(8'h00);
    for (int i = 0; i < 16; i++) begin
      in_pc_valid = 1'b1;
      in_pc_is_directed_to_current = 1'b0;
      in_pc = 8'h40 + 8'(i);
      @(negedge clk);
      checks++; if (in_pc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b exp 1", i, in_pc_ready); end
      tick();
    end
    in_pc = 8'h7F;
    @(negedge clk);
    checks++; if (in_pc_ready !== 1'b0) begin errors++; $display("FAIL full_ready_17 got %b exp 0", in_pc_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_early got %b exp 0", overflow); end
    tick();
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_set got %b exp 1", overflow); end
    tick();
    in_pc_valid = 1'b0;
    out_pc_ready = 1'b1;
    tick();
    out_pc_ready = 1'b0;
    cpu_idle = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (advance_character === 1'b1) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_advance_timeout got %b exp 1", seen); end
    out_pc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h40 + 8'(i)) begin errors++; $display("FAIL full_drain_%0d got v=%b pc=%h exp v=1 pc=%h", i, out_pc_valid, out_pc, 8'h40 + 8'(i)); end
      tick();
    end
    out_pc_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b0) begin errors++; $display("FAIL full_17th_stored got v=%b pc=%h exp v=0", out_pc_valid, out_pc); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        tick();
        break;
      end
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_done_timeout got %b exp 1", seen); end
    do_start(8'h01);
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_clear got %b exp 0", overflow); end
    tick();
    $display("test_full: 16 stored, 17th rejected, overflow sticky until start");
  endtask

  task automatic test_reset_mid_run();
    int done_cnt;
    int adv_cnt;
    do_reset();
    do_start(8'h10);
    for (int i = 0; i < 3; i++) begin
      in_pc_valid = 1'b1;
      in_pc_is_directed_to_current = 1'b0;
      in_pc = 8'h11 + 8'(i);
      tick();
    end
    in_pc_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_pc_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", done); end
    tick();
    do_start(8'h20);
    out_pc_ready = 1'b1;
    cpu_idle = 1'b1;
    @(negedge clk);
    checks++; if (out_pc_valid !== 1'b1 || out_pc !== 8'h20) begin errors++; $display("FAIL midreset_restart got v=%b pc=%h exp v=1 pc=20", out_pc_valid, out_pc); end
    tick();
    out_pc_ready = 1'b0;
    done_cnt = 0;
    adv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (advance_character === 1'b1) adv_cnt++;
      tick();
    end
    checks++; if (done_cnt != 1 || adv_cnt != 0) begin errors++; $display("FAIL midreset_stale got done=%0d adv=%0d exp done=1 adv=0", done_cnt, adv_cnt); end
    $display("test_reset_mid_run: queued PCs discarded");
  endtask

  // Model: mode 0 idle, 1 running, 2 advancing, 3 finishing; queues hold the two PC lists.
  task automatic test_random();
    logic [7:0] cq[$];
    logic [7:0] nq[$];
    logic [7:0] tq[$];
    int   mode;
    int   runs;
    bit   prev_quiet;
    bit   ovf;
    bit   quiet;
    bit   pop;
    bit   e_ready;
    bit   e_valid;
    logic [7:0] e_pc;
    do_reset();
    mode = 0;
    runs = 0;
    prev_quiet = 1'b0;
    ovf = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = (mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      start_pc = 8'($urandom);
      in_pc_valid = ($urandom_range(0, 2) == 0);
      in_pc = 8'($urandom);
      in_pc_is_directed_to_current = ($urandom_range(0, 1) == 1);
      out_pc_ready = ($urandom_range(0, 9) < 6);
      cpu_idle = ($urandom_range(0, 9) < 7);
      at_end_of_string = ($urandom_range(0, 9) == 0);

      e_ready = (mode == 1) && (in_pc_is_directed_to_current ? (cq.size() < 16) : (nq.size() < 16));
      e_valid = (mode == 1) && (cq.size() > 0);
      e_pc = e_valid ? cq[0] : 8'h00;

      @(negedge clk);
      checks++; if (in_pc_ready !== e_ready) begin errors++; $display("FAIL rnd_in_pc_ready cycle %0d got %b exp %b", cyc, in_pc_ready, e_ready); end
      checks++; if (out_pc_valid !== e_valid) begin errors++; $display("FAIL rnd_out_pc_valid cycle %0d got %b exp %b", cyc, out_pc_valid, e_valid); end
      if (e_valid) begin
        checks++; if (out_pc !== e_pc) begin errors++; $display("FAIL rnd_out_pc cycle %0d got %h exp %h", cyc, out_pc, e_pc); end
      end
      checks++; if (advance_character !== (mode == 2)) begin errors++; $display("FAIL rnd_advance cycle %0d got %b exp %b", cyc, advance_character, (mode == 2)); end
      checks++; if (done !== (mode == 3)) begin errors++; $display("FAIL rnd_done cycle %0d got %b exp %b", cyc, done, (mode == 3)); end
      checks++; if (overflow !== ovf) begin errors++; $display("FAIL rnd_overflow cycle %0d got %b exp %b", cyc, overflow, ovf); end

      if (reset) begin
        cq.delete();
        nq.delete();
        mode = 0;
        prev_quiet = 1'b0;
        ovf = 1'b0;
      end else begin
        case (mode)
          0: begin
            if (start) begin
              cq.delete();
              nq.delete();
              cq.push_back(start_pc);
              ovf = 1'b0;
              mode = 1;
            end
            prev_quiet = 1'b0;
          end
          1: begin
            pop = e_valid && out_pc_ready;
            if (in_pc_valid && !e_ready) ovf = 1'b1;
            quiet = (cq.size() == 0) && cpu_idle && !in_pc_valid && !pop;
            if (pop) void'(cq.pop_front());
            if (in_pc_valid && e_ready) begin
              if (in_pc_is_directed_to_current) cq.push_back(in_pc);
              else nq.push_back(in_pc);
            end
            if (quiet && prev_quiet) mode = (nq.size() == 0 || at_end_of_string) ? 3 : 2;
            prev_quiet = quiet;
          end
          2: begin
            tq = cq;
            cq = nq;
            nq = tq;
            mode = 1;
            prev_quiet = 1'b0;
          end
          default: begin
            runs++;
            $display("test_random: run %0d finished at cycle %0d", runs, cyc);
            cq.delete();
            nq.delete();
            mode = 0;
            prev_quiet = 1'b0;
          end
        endcase
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    $display("test_random: %0d runs completed", runs);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_thread();
    test_split();
    test_empty_next();
    test_end_of_string();
    test_full();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regex_pc_scheduler.md
Name: regex_pc_scheduler

Overview:
- Thread scheduler sitting on both sides of the regex CPU: collects PCs the CPU emits on its output PC port and feeds PCs back to its input PC port.
- Holds two ping-pong PC FIFOs:
  - the "current" FIFO holds threads for the character now presented;
  - the "next" FIFO holds threads for the following character.
- When the current character is fully drained, pulses a character-advance request to the character source and swaps FIFO roles.
- Detects end of run: no live threads, or end of string reached.

Parameters:
- PC_WIDTH, 8, width of a program counter.
- FIFO_DEPTH_LOG2, 4, log2 of each FIFO's depth (16 entries each).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run (honoured only in S_IDLE).
- start_pc  input  PC_WIDTH  first PC, pushed into current FIFO on start.
- in_pc_valid  input  1  CPU emits a PC.
- in_pc  input  PC_WIDTH  emitted PC.
- in_pc_is_directed_to_current  input  1  1 = current FIFO, 0 = next FIFO.
- in_pc_ready  output  1  scheduler accepts in_pc.
- out_pc_valid  output  1  PC available for CPU.
- out_pc  output  PC_WIDTH  PC to CPU.
- out_pc_ready  input  1  CPU takes PC (CPU idle-ready).
- cpu_idle  input  1  CPU in idle state, no instruction in flight.
- at_end_of_string  input  1  current character is the string terminator.
- advance_character  output  1  one-cycle pulse; character source presents next character from the following cycle.
- done  output  1  one-cycle pulse at end of run.
- overflow  output  1  sticky: a push was back-pressured while the target FIFO was full; cleared on reset/start.

Behaviour:
- States: S_IDLE, S_RUN, S_ADVANCE, S_DONE.
- Reset values:
  - state S_IDLE; both FIFOs empty (read/write pointers 0); cur_sel 0; quiet_q 0.
  - outputs: in_pc_ready 0, out_pc_valid 0, out_pc 0, advance_character 0, done 0, overflow 0.
- Reset mid-run discards all queued PCs; nothing is emitted the cycle after.
- S_IDLE:
  - on start, both FIFOs flush, start_pc is written to the current FIFO, overflow clears, then S_RUN.
  - all handshake outputs are 0.
- S_RUN, FIFO selection:
  - cur_sel selects which physical FIFO is "current".
- S_RUN, push:
  - in_pc_ready = NOT full(target), where target = current if in_pc_is_directed_to_current, else next.
  - Write when in_pc_valid AND in_pc_ready.
- S_RUN, pop:
  - out_pc_valid = NOT empty(current); out_pc = head of current (combinational, first-word fall-through).
  - Pop on out_pc_valid AND out_pc_ready.
- Simultaneous push and pop on the current FIFO is allowed.
  - Ready still uses the pre-pop full flag (conservative).
  - Count is unchanged.
- Pointers are FIFO_DEPTH_LOG2+1 bits and wrap modulo 2x depth.
  - full: MSBs differ and the low bits are equal.
  - empty: pointers are equal.
- quiet condition = current empty AND cpu_idle AND NOT in_pc_valid AND NOT (pop this cycle).
  - quiet_q registers quiet each cycle.
  - Advance decision requires quiet AND quiet_q, so one idle cycle is required after the last pop before the CPU's busy state is trusted.
- On decision:
  - next empty OR at_end_of_string → S_DONE.
  - otherwise → S_ADVANCE.
- S_ADVANCE (exactly 1 cycle):
  - advance_character = 1; toggle cur_sel; quiet_q cleared; in_pc_ready = 0, out_pc_valid = 0; then S_RUN.
- S_DONE (1 cycle):
  - done = 1; both FIFOs flushed; → S_IDLE.
- Latency:
  - push-to-visible on out_pc: 1 cycle.
  - last activity to advance_character: minimum 2 cycles.
- start asserted outside S_IDLE is ignored.

Test Plan:
- Single thread: start_pc=0x05; CPU pops, returns 0x06 as next → advance_character pulses exactly once, 2 cycles after the CPU is idle; then out_pc=0x06 is presented.
- Split: CPU returns 0x0A and 0x0B as current in consecutive cycles → out_pc gives 0x0A then 0x0B in order, with no advance in between.
- Empty next: CPU pops 0x00, emits nothing, idles → done pulses 1 cycle; advance_character never asserts; state returns to S_IDLE.
- End of string: next holds 0x03 and at_end_of_string=1 at decision → done, not advance.
- Full: push 16 PCs to next without popping → in_pc_ready drops to 0 on the 17th; overflow goes to 1 on a held in_pc_valid; the 17th entry is not stored.
- Reset mid-run with 3 queued PCs → the next cycle has out_pc_valid=0 and done=0; a new start with start_pc=0x20 yields out_pc=0x20.
